// File: rtl/nios_conv3x3_filter.sv
// Streaming 3x3 convolution of an 8-bit greyscale raster, zero padded edges.
// Optional build macro: CONV3X3_SATURATE_EN clamps results to 0..255 (else wrap).
// Ports:
//   Clock, Reset (async, active high)
//   Filter_en (1 = convolve, 0 = centre-pixel bypass)
//   C_m1_m1..C_p1_p1 signed coefficients (row/col offset), C_ws right shift
//   in_sof/in_valid/in_pixel/in_ready : pixel stream in, raster order
//   out_valid/out_pixel/out_sof : result strobe, no backpressure
//   frame_done : pulse after the last result of a frame
module nios_conv3x3_filter #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COEF_W     = 16
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Filter_en,
   input  logic signed [COEF_W-1:0] C_m1_m1,
   input  logic signed [COEF_W-1:0] C_m1_0,
   input  logic signed [COEF_W-1:0] C_m1_p1,
   input  logic signed [COEF_W-1:0] C_0_m1,
   input  logic signed [COEF_W-1:0] C_0_0,
   input  logic signed [COEF_W-1:0] C_0_p1,
   input  logic signed [COEF_W-1:0] C_p1_m1,
   input  logic signed [COEF_W-1:0] C_p1_0,
   input  logic signed [COEF_W-1:0] C_p1_p1,
   input  logic [4:0]               C_ws,
   input  logic                     in_sof,
   input  logic                     in_valid,
   input  logic [7:0]               in_pixel,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [7:0]               out_pixel,
   output logic                     out_sof,
   output logic                     frame_done
);

   localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int KW   = $clog2(NPIX + IMG_WIDTH + 1);
   localparam int CW   = $clog2(IMG_WIDTH);
   localparam int RW   = $clog2(IMG_HEIGHT + 1);
   localparam int PW   = COEF_W + 9;
   localparam int SW   = COEF_W + 13;

   localparam logic [KW-1:0] K_LAST  = KW'(NPIX - 1);
   localparam logic [KW-1:0] K_END   = KW'(NPIX + IMG_WIDTH);
   localparam logic [KW-1:0] K_FIRST = KW'(IMG_WIDTH + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t state, state_nx;

   logic [KW-1:0] k_cnt, bk;
   logic [CW-1:0] col, bcol, ocol;
   logic [RW-1:0] orow;
   logic          beat, restart, en, busy;
   logic [7:0]    pix;

   logic [7:0] lb1 [IMG_WIDTH];
   logic [7:0] lb2 [IMG_WIDTH];
   logic [7:0] win [3][3];

   logic v0, m_t, m_b, m_l, m_r, sof0;
   logic v1, byp1, sof1;
   logic v2, byp2, sof2;
   logic [7:0] ctr1, ctr2;
   logic [4:0] ws1, ws2;
   logic signed [PW-1:0] prod   [9];
   logic signed [PW-1:0] prod_d [9];
   logic signed [COEF_W-1:0] cf [9];
   logic [7:0] tap [9];
   logic signed [SW-1:0] sum_d, sum2;
   logic [7:0] res;

   // Control: which beat (real or flush) moves the window this cycle.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      beat     = 1'b0;
      restart  = 1'b0;
      pix      = 8'd0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && in_sof) begin
               beat     = 1'b1;
               restart  = 1'b1;
               pix      = in_pixel;
               state_nx = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               beat    = 1'b1;
               restart = in_sof;
               pix     = in_pixel;
               if (!in_sof && k_cnt == K_LAST)
                  state_nx = FLUSH;
            end
         end
         FLUSH: begin
            beat = 1'b1;
            if (k_cnt == K_END)
               state_nx = DONE;
         end
         DONE: begin
            if (!busy)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // A restarting beat is pixel 0 of the new frame.
   assign bk   = restart ? '0 : k_cnt;
   assign bcol = restart ? '0 : col;
   assign en   = beat && (bk >= K_FIRST);
   assign busy = v0 | v1 | v2;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         k_cnt <= '0;
         col   <= '0;
         ocol  <= '0;
         orow  <= '0;
      end else begin
         state <= state_nx;
         if (beat) begin
            k_cnt <= bk + KW'(1);
            col   <= (bcol == COL_MAX) ? '0 : bcol + CW'(1);
         end
         if (restart) begin
            ocol <= '0;
            orow <= '0;
         end else if (en) begin
            if (ocol == COL_MAX) begin
               ocol <= '0;
               orow <= orow + RW'(1);
            end else begin
               ocol <= ocol + CW'(1);
            end
         end
      end
   end

   // Line buffers and window shift; contents survive reset by design.
   // Window columns are always row-aligned to the centre column's row,
   // so only edge masking is needed, never realignment.
   always_ff @(posedge Clock) begin
      if (beat) begin
         lb1[bcol] <= pix;
         lb2[bcol] <= lb1[bcol];
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb2[bcol];
         win[1][2] <= lb1[bcol];
         win[2][2] <= pix;
      end
   end

   assign cf[0] = C_m1_m1;
   assign cf[1] = C_m1_0;
   assign cf[2] = C_m1_p1;
   assign cf[3] = C_0_m1;
   assign cf[4] = C_0_0;
   assign cf[5] = C_0_p1;
   assign cf[6] = C_p1_m1;
   assign cf[7] = C_p1_0;
   assign cf[8] = C_p1_p1;

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if ((r == 0 && m_t) || (r == 2 && m_b) ||
                (c == 0 && m_l) || (c == 2 && m_r))
               tap[r*3+c] = 8'd0;
            else
               tap[r*3+c] = win[r][c];
         end
      end
      for (int i = 0; i < 9; i++)
         prod_d[i] = PW'($signed({1'b0, tap[i]})) * PW'(cf[i]);
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < 9; i++)
         sum_d = sum_d + SW'(prod[i]);
   end

`ifdef CONV3X3_SATURATE_EN
   logic signed [SW-1:0] shifted;
   always_comb begin
      shifted = sum2 >>> ws2;
      if (shifted[SW-1])
         res = 8'd0;
      else if (|shifted[SW-2:8])
         res = 8'd255;
      else
         res = shifted[7:0];
   end
`else
   always_comb begin
      res = 8'(sum2 >>> ws2);
   end
`endif

   // Pipeline: window -> products -> sum -> shift/clip; abort squashes all.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         v0         <= 1'b0;
         m_t        <= 1'b0;
         m_b        <= 1'b0;
         m_l        <= 1'b0;
         m_r        <= 1'b0;
         sof0       <= 1'b0;
         v1         <= 1'b0;
         byp1       <= 1'b0;
         sof1       <= 1'b0;
         ctr1       <= 8'd0;
         ws1        <= 5'd0;
         v2         <= 1'b0;
         byp2       <= 1'b0;
         sof2       <= 1'b0;
         ctr2       <= 8'd0;
         ws2        <= 5'd0;
         sum2       <= '0;
         out_valid  <= 1'b0;
         out_pixel  <= 8'd0;
         out_sof    <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < 9; i++)
            prod[i] <= '0;
      end else begin
         v0 <= en;
         if (en) begin
            m_t  <= (orow == '0);
            m_b  <= (orow == ROW_MAX);
            m_l  <= (ocol == '0);
            m_r  <= (ocol == COL_MAX);
            sof0 <= (orow == '0) && (ocol == '0);
         end
         v1 <= v0 && !restart;
         if (v0) begin
            for (int i = 0; i < 9; i++)
               prod[i] <= prod_d[i];
            ctr1 <= win[1][1];
            ws1  <= C_ws;
            byp1 <= !Filter_en;
            sof1 <= sof0;
         end
         v2 <= v1 && !restart;
         if (v1) begin
            sum2 <= sum_d;
            ctr2 <= ctr1;
            ws2  <= ws1;
            byp2 <= byp1;
            sof2 <= sof1;
         end
         out_valid <= v2 && !restart;
         out_sof   <= v2 && sof2 && !restart;
         if (v2)
            out_pixel <= byp2 ? ctr2 : res;
         frame_done <= (state == DONE) && !busy;
      end
   end

endmodule
